// File: rtl/alu_pkg.sv
// Shared ALU-side types and constants for the issue controller and its FIFO.
// The transaction struct mirrors the ALU input pins one-for-one.
package alu_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int CMD_WIDTH  = 4;

   localparam logic [CMD_WIDTH-1:0] CMD_MUL_INC = 4'd9;
   localparam logic [CMD_WIDTH-1:0] CMD_MUL_SHL = 4'd10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} issue_state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] opa;
      logic [DATA_WIDTH-1:0] opb;
      logic                  cin;
      logic                  mode;
      logic [CMD_WIDTH-1:0]  cmd;
      logic [1:0]            inp_valid;
   } alu_txn_t;

   // Multiply commands only exist in arithmetic mode.
   function automatic logic is_mul(input alu_txn_t t);
      return t.mode && ((t.cmd == CMD_MUL_INC) || (t.cmd == CMD_MUL_SHL));
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Upstream transaction port plus ALU-side pins of the issue controller.
// The controller uses the slave view; the stimulus side uses the master view.
interface alu_issue_ctrl_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   logic                           CE;
   logic                           in_valid;
   logic                           in_ready;
   logic [alu_pkg::DATA_WIDTH-1:0] in_opa;
   logic [alu_pkg::DATA_WIDTH-1:0] in_opb;
   logic                           in_cin;
   logic                           in_mode;
   logic [alu_pkg::CMD_WIDTH-1:0]  in_cmd;
   logic [1:0]                     in_inp_valid;
   logic [alu_pkg::DATA_WIDTH-1:0] OPA;
   logic [alu_pkg::DATA_WIDTH-1:0] OPB;
   logic                           CIN;
   logic                           MODE;
   logic [alu_pkg::CMD_WIDTH-1:0]  CMD;
   logic [1:0]                     INP_VALID;
   logic                           res_expected;
   logic                           busy;
   logic [LVL_W-1:0]               fifo_level;

   modport slave (
      input  CE, in_valid, in_opa, in_opb, in_cin, in_mode, in_cmd, in_inp_valid,
      output in_ready, OPA, OPB, CIN, MODE, CMD, INP_VALID, res_expected, busy, fifo_level
   );

   modport master (
      output CE, in_valid, in_opa, in_opb, in_cin, in_mode, in_cmd, in_inp_valid,
      input  in_ready, OPA, OPB, CIN, MODE, CMD, INP_VALID, res_expected, busy, fifo_level
   );

endinterface

// File: rtl/alu_issue_fifo.sv
// Small synchronous FIFO of ALU transactions; head is visible combinationally
// so the issue stage can register it straight onto the ALU pins.
module alu_issue_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  alu_txn_t         push_data,
   input  logic             pop,
   output alu_txn_t         head,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int PTR_W = $clog2(DEPTH);

   alu_txn_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_reg == LVL_W'(DEPTH));
   assign empty   = (level_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];
   assign level   = level_reg;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Buffers ALU transactions and issues them one at a time, spaced by the
// command-dependent ALU latency, with a pulse marking each valid result.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_LAT   = 1,
   parameter int MUL_LAT    = 2
) (
   input  logic             clk,
   input  logic             reset,
   alu_issue_ctrl_if.slave  bus
);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(BASE_LAT - 1);
   localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 1);

   issue_state_t     state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   alu_txn_t         out_reg, out_next;
   logic             res_reg, res_next;
   logic             slot_free;
   logic             pop;
   logic             push;
   alu_txn_t         push_txn;
   alu_txn_t         head;
   logic             full;
   logic             empty;
   logic [LVL_W-1:0] level;

   assign push_txn = '{opa: bus.in_opa, opb: bus.in_opb, cin: bus.in_cin,
                       mode: bus.in_mode, cmd: bus.in_cmd, inp_valid: bus.in_inp_valid};
   assign push     = bus.in_valid;

   alu_issue_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_txn),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         out_reg   <= '0;
         res_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         out_reg   <= out_next;
         res_reg   <= res_next;
      end
   end

   // slot_free marks an edge where the ALU can take a new operation: idle,
   // or the previous one's result lands in the next cycle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      out_next   = out_reg;
      res_next   = res_reg;
      slot_free  = 1'b0;
      pop        = 1'b0;
      if (bus.CE) begin
         res_next = 1'b0;
         case (state_reg)
            IDLE: slot_free = 1'b1;
            ISSUE: begin
               out_next.inp_valid = 2'b00;
               if (cnt_reg == '0) begin
                  res_next  = 1'b1;
                  slot_free = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
            WAIT: begin
               if (cnt_reg == CNT_W'(1)) begin
                  res_next  = 1'b1;
                  slot_free = 1'b1;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
         if (slot_free) begin
            if (!empty) begin
               pop        = 1'b1;
               out_next   = head;
               cnt_next   = is_mul(head) ? MUL_CNT : BASE_CNT;
               state_next = ISSUE;
            end else begin
               state_next = IDLE;
            end
         end
      end
   end

   assign bus.in_ready     = !full;
   assign bus.OPA          = out_reg.opa;
   assign bus.OPB          = out_reg.opb;
   assign bus.CIN          = out_reg.cin;
   assign bus.MODE         = out_reg.mode;
   assign bus.CMD          = out_reg.cmd;
   assign bus.INP_VALID    = out_reg.inp_valid;
   assign bus.res_expected = res_reg;
   assign bus.busy         = (state_reg != IDLE) || !empty;
   assign bus.fifo_level   = level;

endmodule
